// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-side bundle of the shared AHB bus: manager requests, muxed owner control,
// bus handshake, and the grant/owner indices that steer the bus muxes.
interface ahb_bus_arbiter_if #(
    parameter int unsigned NUM_MGR = 4
);
    localparam int unsigned MW = $clog2(NUM_MGR);

    logic [NUM_MGR-1:0] req_i;
    logic [NUM_MGR-1:0] lock_i;
    logic [1:0]         HTRANS;
    logic [2:0]         HBURST;
    logic               HMASTLOCK;
    logic               HREADY;
    logic               HRESP;
    logic [NUM_MGR-1:0] grant_o;
    logic [MW-1:0]      HMASTER;
    logic [MW-1:0]      hmaster_data;
    logic               arb_busy_o;

    // Managers and bus fabric: drive requests and bus state, observe the grant.
    modport master (
        output req_i, lock_i, HTRANS, HBURST, HMASTLOCK, HREADY, HRESP,
        input  grant_o, HMASTER, hmaster_data, arb_busy_o
    );

    // Arbiter: observes requests and bus state, drives the grant.
    modport slave (
        input  req_i, lock_i, HTRANS, HBURST, HMASTLOCK, HREADY, HRESP,
        output grant_o, HMASTER, hmaster_data, arb_busy_o
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: shares one AHB bus among NUM_MGR managers with a registered
// one-hot grant. The grant only moves at legal transfer boundaries: never inside a
// defined-length burst or a locked sequence. Round-robin by default.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module ahb_bus_arbiter #(
    parameter int unsigned NUM_MGR     = 4,
    parameter int unsigned DEFAULT_MGR = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_bus_arbiter_if.slave bus
);
    localparam int unsigned MW = $clog2(NUM_MGR);
    localparam int unsigned CW = 4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BR_SINGLE = 3'b000;

    localparam logic [MW-1:0]      DEF_IDX = MW'(DEFAULT_MGR);
    localparam logic [NUM_MGR-1:0] ONE     = NUM_MGR'(1);
    localparam logic [NUM_MGR-1:0] DEF_GNT = ONE << DEFAULT_MGR;

    typedef enum logic [1:0] {
        ST_PARK,
        ST_OWN,
        ST_BURST,
        ST_LOCKED
    } state_t;

    state_t             state;
    logic [CW-1:0]      beat_cnt;
    logic [MW-1:0]      owner;
    logic [MW-1:0]      data_owner;
    logic [NUM_MGR-1:0] grant;
    logic               busy;
`ifndef ARB_FIXED_PRIO_EN
    logic [MW-1:0]      rr;
`endif

    logic               accepted;
    logic               owner_req;
    logic               lock_go;
    logic               burst_go;
    logic               own_arb;
    logic               burst_end;
    logic               do_arb;
    logic [CW-1:0]      burst_len_m1;
    logic               win_any;
    logic [MW-1:0]      win_idx;
`ifndef ARB_FIXED_PRIO_EN
    int unsigned        cand;
`endif

    // Lock requests carry no priority; folded away so the port stays connected.
    logic               lock_unused;
    assign lock_unused = ^bus.lock_i;

    assign bus.grant_o      = grant;
    assign bus.HMASTER      = owner;
    assign bus.hmaster_data = data_owner;
    assign bus.arb_busy_o   = busy;

    // Transfer classification and arbitration-point detection for the current cycle.
    always_comb begin
        accepted  = bus.HREADY & (bus.HTRANS != TR_IDLE);
        owner_req = bus.req_i[owner];
        case (bus.HBURST[2:1])
            2'b01:   burst_len_m1 = CW'(3);
            2'b10:   burst_len_m1 = CW'(7);
            2'b11:   burst_len_m1 = CW'(15);
            default: burst_len_m1 = CW'(0);
        endcase
        lock_go   = accepted & bus.HMASTLOCK;
        burst_go  = accepted & (bus.HTRANS == TR_NONSEQ) & (bus.HBURST[2:1] != 2'b00);
        // Undefined-length INCR only yields on IDLE or a dropped request.
        own_arb   = (bus.HTRANS == TR_IDLE)
                  | (accepted & (bus.HBURST == BR_SINGLE))
                  | ~owner_req;
        // An ERROR completion cancels the burst just like its last beat.
        burst_end = bus.HRESP | ((bus.HTRANS == TR_SEQ) & (beat_cnt <= CW'(1)));
        case (state)
            ST_PARK:  do_arb = bus.HREADY & (|bus.req_i);
            ST_OWN:   do_arb = bus.HREADY & ~lock_go & ~burst_go & own_arb;
            ST_BURST: do_arb = bus.HREADY & burst_end;
            default:  do_arb = 1'b0;
        endcase
    end

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-indexed requester wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = DEF_IDX;
        for (int k = int'(NUM_MGR) - 1; k >= 0; k--) begin
            if (bus.req_i[MW'(k)]) begin
                win_any = 1'b1;
                win_idx = MW'(k);
            end
        end
    end
`else
    // Round-robin: search from the manager after the last winner, wrapping.
    always_comb begin
        win_any = 1'b0;
        win_idx = DEF_IDX;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_MGR; k++) begin
            cand = 32'(rr) + k;
            if (cand >= NUM_MGR) begin
                cand = cand - NUM_MGR;
            end
            if (!win_any && bus.req_i[MW'(cand)]) begin
                win_any = 1'b1;
                win_idx = MW'(cand);
            end
        end
    end
`endif

    // Arbiter FSM; every change is qualified by HREADY so wait states freeze it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_PARK;
            beat_cnt   <= '0;
            owner      <= DEF_IDX;
            data_owner <= DEF_IDX;
            grant      <= DEF_GNT;
            busy       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr         <= DEF_IDX;
`endif
        end else if (bus.HREADY) begin
            data_owner <= owner;
            case (state)
                ST_OWN: begin
                    if (lock_go) begin
                        state <= ST_LOCKED;
                        busy  <= 1'b1;
                    end else if (burst_go) begin
                        state    <= ST_BURST;
                        beat_cnt <= burst_len_m1;
                        busy     <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (burst_end) begin
                        beat_cnt <= '0;
                    end else if (bus.HTRANS == TR_SEQ) begin
                        beat_cnt <= beat_cnt - CW'(1);
                    end
                end
                ST_LOCKED: begin
                    if ((bus.HTRANS == TR_IDLE) && !bus.HMASTLOCK) begin
                        state <= ST_OWN;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (do_arb) begin
                busy <= 1'b0;
                if (win_any) begin
                    state <= ST_OWN;
                    owner <= win_idx;
                    grant <= ONE << win_idx;
`ifndef ARB_FIXED_PRIO_EN
                    rr    <= win_idx;
`endif
                end else begin
                    state <= ST_PARK;
                    owner <= DEF_IDX;
                    grant <= DEF_GNT;
                end
            end
        end
    end

    // Grant stays one-hot and always names the HMASTER index.
    property p_grant_consistent;
        @(posedge HCLK) disable iff (!HRESETn)
            $onehot(grant) && (grant == (ONE << owner));
    endproperty
    a_grant_consistent: assert property (p_grant_consistent);

    // The grant is pinned while busy.
    property p_busy_matches_state;
        @(posedge HCLK) disable iff (!HRESETn)
            busy == ((state == ST_BURST) || (state == ST_LOCKED));
    endproperty
    a_busy_matches_state: assert property (p_busy_matches_state);

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios followed by randomized legal bus
// traffic, all checked against a behavioural model of the arbitration rules.
module tb_ahb_bus_arbiter;
    localparam int NUM_MGR     = 4;
    localparam int DEFAULT_MGR = 0;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam int M_PARK   = 0;
    localparam int M_OWN    = 1;
    localparam int M_BURST  = 2;
    localparam int M_LOCKED = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ahb_bus_arbiter_if #(.NUM_MGR(NUM_MGR)) bus ();

    ahb_bus_arbiter #(
        .NUM_MGR    (NUM_MGR),
        .DEFAULT_MGR(DEFAULT_MGR)
    ) dut (
        .HCLK   (clk),
        .HRESETn(rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, how many beats remain, last winner.
    int m_state;
    int m_owner;
    int m_data;
    int m_rr;
    int m_left;

    logic [NUM_MGR-1:0] r_req;
    logic [1:0]         r_trans;
    logic [2:0]         r_burst;
    logic               r_lock;
    logic               r_ready;
    logic               r_resp;
    logic               err_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_PARK;
        m_owner = DEFAULT_MGR;
        m_data  = DEFAULT_MGR;
        m_rr    = DEFAULT_MGR;
        m_left  = 0;
    endtask

    function automatic int pick(input logic [NUM_MGR-1:0] req);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_MGR; i++) if (req[i]) return i;
`else
        for (int k = 1; k <= NUM_MGR; k++) begin
            int c;
            c = (m_rr + k) % NUM_MGR;
            if (req[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_arb(input logic [NUM_MGR-1:0] req);
        int w;
        w = pick(req);
        if (w < 0) begin
            m_state = M_PARK;
            m_owner = DEFAULT_MGR;
        end else begin
            m_state = M_OWN;
            m_owner = w;
            m_rr    = w;
        end
    endtask

    task automatic model_edge(input logic [NUM_MGR-1:0] req, input logic [1:0] trans,
                              input logic [2:0] burst, input logic mlock,
                              input logic ready, input logic resp);
        bit acc;
        if (!ready) return;
        acc    = (trans != TR_IDLE);
        m_data = m_owner;
        case (m_state)
            M_PARK: if (req != 0) model_arb(req);
            M_OWN: begin
                if (acc && mlock) begin
                    m_state = M_LOCKED;
                end else if (acc && trans == TR_NONSEQ && burst >= 3'd2) begin
                    m_state = M_BURST;
                    m_left  = (2 << int'(burst[2:1])) - 1;
                end else if (trans == TR_IDLE || (acc && burst == 3'd0) || !req[m_owner]) begin
                    model_arb(req);
                end
            end
            M_BURST: begin
                if (resp) begin
                    m_left = 0;
                    model_arb(req);
                end else if (trans == TR_SEQ) begin
                    if (m_left <= 1) begin
                        m_left = 0;
                        model_arb(req);
                    end else begin
                        m_left--;
                    end
                end
            end
            default: if (trans == TR_IDLE && !mlock) m_state = M_OWN;
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, " grant"}, 32'(bus.grant_o), 32'(1) << m_owner);
        check({tag, " hmaster"}, 32'(bus.HMASTER), 32'(m_owner));
        check({tag, " hmaster_data"}, 32'(bus.hmaster_data), 32'(m_data));
        check({tag, " busy"}, 32'(bus.arb_busy_o),
              32'((m_state == M_BURST) || (m_state == M_LOCKED)));
    endtask

    // One bus cycle: drive inputs, advance model on the edge, compare after it.
    task automatic step(input logic [NUM_MGR-1:0] req, input logic [1:0] trans,
                        input logic [2:0] burst, input logic mlock,
                        input logic ready, input logic resp, input string tag);
        bus.req_i     = req;
        bus.lock_i    = NUM_MGR'($urandom);
        bus.HTRANS    = trans;
        bus.HBURST    = burst;
        bus.HMASTLOCK = mlock;
        bus.HREADY    = ready;
        bus.HRESP     = resp;
        @(posedge clk);
        model_edge(req, trans, burst, mlock, ready, resp);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " grant"}, 32'(bus.grant_o), 32'(1) << DEFAULT_MGR);
        check({tag, " hmaster"}, 32'(bus.HMASTER), 32'(DEFAULT_MGR));
        check({tag, " hmaster_data"}, 32'(bus.hmaster_data), 32'(DEFAULT_MGR));
        check({tag, " busy"}, 32'(bus.arb_busy_o), 32'(0));
    endtask

    initial begin
        logic [1:0] seq_tr [12];
        logic       seq_rd [12];
        rst_n         = 1'b0;
        bus.req_i     = '0;
        bus.lock_i    = '0;
        bus.HTRANS    = TR_IDLE;
        bus.HBURST    = 3'd0;
        bus.HMASTLOCK = 1'b0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin handover on SINGLE transfers.
        step(4'b0110, TR_IDLE, 3'd0, 1'b0, 1'b1, 1'b0, "rr_first");
        check("rr_first_lit", 32'(bus.grant_o), 32'b0010);
        step(4'b0110, TR_NONSEQ, 3'd0, 1'b0, 1'b1, 1'b0, "rr_single1");
`ifdef ARB_FIXED_PRIO_EN
        check("rr_single1_lit", 32'(bus.grant_o), 32'b0010);
`else
        check("rr_single1_lit", 32'(bus.grant_o), 32'b0100);
`endif
        step(4'b0110, TR_NONSEQ, 3'd0, 1'b0, 1'b1, 1'b0, "rr_single2");
        check("rr_single2_lit", 32'(bus.grant_o), 32'b0010);

        // INCR8 on mgr2 with BUSY and wait states; grant pinned until the 8th beat.
        step(4'b0100, TR_NONSEQ, 3'd0, 1'b0, 1'b1, 1'b0, "to_mgr2");
        step(4'b1111, TR_NONSEQ, 3'b101, 1'b0, 1'b1, 1'b0, "incr8_start");
        seq_tr = '{TR_SEQ, TR_BUSY, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ,
                   TR_BUSY, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ};
        seq_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            step(4'b1111, seq_tr[i], 3'b101, 1'b0, seq_rd[i], 1'b0, "incr8_beat");
            if (i < 11) begin
                check("incr8_pinned_lit", 32'(bus.grant_o), 32'b0100);
                check("incr8_busy_lit", 32'(bus.arb_busy_o), 32'(1));
            end
        end
`ifndef ARB_FIXED_PRIO_EN
        check("incr8_handover_lit", 32'(bus.grant_o), 32'b1000);
`endif
        check("incr8_done_busy_lit", 32'(bus.arb_busy_o), 32'(0));

        // Locked sequence on the current owner holds the grant until unlocked IDLE.
        step(4'b1111, TR_NONSEQ, 3'd0, 1'b1, 1'b1, 1'b0, "lock_1");
        step(4'b1111, TR_NONSEQ, 3'd0, 1'b1, 1'b1, 1'b0, "lock_2");
        step(4'b1111, TR_NONSEQ, 3'd0, 1'b1, 1'b0, 1'b0, "lock_wait");
        step(4'b1111, TR_NONSEQ, 3'd0, 1'b1, 1'b1, 1'b0, "lock_3");
        step(4'b1111, TR_IDLE, 3'd0, 1'b1, 1'b1, 1'b0, "lock_idle_held");
`ifndef ARB_FIXED_PRIO_EN
        check("lock_held_lit", 32'(bus.grant_o), 32'b1000);
`endif
        check("lock_busy_lit", 32'(bus.arb_busy_o), 32'(1));
        step(4'b1111, TR_IDLE, 3'd0, 1'b0, 1'b1, 1'b0, "lock_release");
        step(4'b1111, TR_IDLE, 3'd0, 1'b0, 1'b1, 1'b0, "after_lock");
`ifndef ARB_FIXED_PRIO_EN
        check("after_lock_lit", 32'(bus.grant_o), 32'b0001);
`endif

        // ERROR on beat 3 of INCR16 cancels the burst and hands over.
        step(4'b1111, TR_NONSEQ, 3'b111, 1'b0, 1'b1, 1'b0, "incr16_start");
        step(4'b1111, TR_SEQ, 3'b111, 1'b0, 1'b1, 1'b0, "incr16_b2");
        step(4'b1111, TR_SEQ, 3'b111, 1'b0, 1'b1, 1'b0, "incr16_b3");
        step(4'b1111, TR_SEQ, 3'b111, 1'b0, 1'b0, 1'b1, "err_first");
        check("err_first_busy_lit", 32'(bus.arb_busy_o), 32'(1));
        step(4'b1111, TR_IDLE, 3'b111, 1'b0, 1'b1, 1'b1, "err_second");
`ifndef ARB_FIXED_PRIO_EN
        check("err_handover_lit", 32'(bus.grant_o), 32'b0010);
`endif
        check("err_busy_lit", 32'(bus.arb_busy_o), 32'(0));

        // Asynchronous reset in the middle of a WRAP4.
        step(4'b1111, TR_NONSEQ, 3'b010, 1'b0, 1'b1, 1'b0, "wrap4_start");
        step(4'b1111, TR_SEQ, 3'b010, 1'b0, 1'b1, 1'b0, "wrap4_b2");
        check("wrap4_busy_lit", 32'(bus.arb_busy_o), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        bus.req_i  = '0;
        bus.HTRANS = TR_IDLE;
        @(posedge clk);
        #1;
        check_reset_values("reset_hold");
        rst_n = 1'b1;

        // Randomized traffic kept legal with respect to the model's view of the bus.
        err_pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r_req   = NUM_MGR'($urandom);
            if ($urandom_range(0, 7) == 0) r_req = '0;
            r_ready = ($urandom_range(0, 3) != 0);
            r_resp  = 1'b0;
            r_lock  = 1'b0;
            r_burst = 3'($urandom);
            r_trans = 2'($urandom);
            if (err_pending) begin
                r_resp      = 1'b1;
                r_ready     = 1'b1;
                r_trans     = TR_IDLE;
                err_pending = 1'b0;
            end else if (m_state == M_BURST) begin
                r_trans = ($urandom_range(0, 3) != 0) ? TR_SEQ : TR_BUSY;
                if ($urandom_range(0, 15) == 0) begin
                    r_resp      = 1'b1;
                    r_ready     = 1'b0;
                    err_pending = 1'b1;
                end
            end else if (m_state == M_LOCKED) begin
                r_lock = ($urandom_range(0, 3) != 0);
                if (!r_lock) r_trans = TR_IDLE;
            end else begin
                r_lock = ($urandom_range(0, 9) == 0);
            end
            step(r_req, r_trans, r_burst, r_lock, r_ready, r_resp, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
